// File: rtl/regfile_wb_queue.sv
// In-order write-back queue merging ALU and load results onto the register
// file's single write port, with a per-source busy lookup for decode.
module regfile_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [4:0]             alu_dest,
  input  logic [31:0]            alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [4:0]             mem_dest,
  input  logic [31:0]            mem_data,
  input  logic [4:0]             s1,
  input  logic [4:0]             s2,
  output logic                   s1_busy,
  output logic                   s2_busy,
  output logic [4:0]             d,
  output logic [31:0]            rd,
  output logic                   rwe,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [4:0]    r_dest [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [4:0]    r_d;
  logic [31:0]   r_rd;
  logic          r_rwe;

  logic          w_pop;
  logic [CW-1:0] w_free;
  logic          w_memAcc;
  logic          w_aluAcc;
  logic          w_memEnq;
  logic          w_aluEnq;
  logic [1:0]    w_enqN;
  logic [PW-1:0] w_aluSlot;
  logic [DEPTH-1:0] w_live;
  logic [DEPTH-1:0] w_hit1;
  logic [DEPTH-1:0] w_hit2;

  // The draining entry frees its slot in the same cycle, so a full queue still offers one slot.
  assign w_pop  = (r_count != '0);
  assign w_free = CW'(DEPTH) - r_count + CW'(w_pop);

  assign mem_ready = reset_n & (w_free >= CW'(1));
  assign alu_ready = reset_n & ((w_free >= CW'(2)) | ((w_free >= CW'(1)) & ~mem_valid));

  assign w_memAcc  = mem_valid & mem_ready;
  assign w_aluAcc  = alu_valid & alu_ready;
  assign w_memEnq  = w_memAcc & (mem_dest != 5'd0);
  assign w_aluEnq  = w_aluAcc & (alu_dest != 5'd0);
  assign w_enqN    = {1'b0, w_memEnq} + {1'b0, w_aluEnq};
  assign w_aluSlot = r_tail + PW'(w_memEnq);

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [PW-1:0] w_offset;
    assign w_offset  = PW'(i) - r_head;
    assign w_live[i] = ({1'b0, w_offset} < r_count);
    assign w_hit1[i] = w_live[i] & (r_dest[i] == s1);
    assign w_hit2[i] = w_live[i] & (r_dest[i] == s2);
  end

  // The output-register term covers the cycle in which the register file is still committing.
  assign s1_busy = (s1 != 5'd0) & ((|w_hit1) | (r_rwe & (r_d == s1)));
  assign s2_busy = (s2 != 5'd0) & ((|w_hit2) | (r_rwe & (r_d == s2)));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_rwe   <= 1'b0;
      r_d     <= '0;
      r_rd    <= '0;
    end else begin
      r_rwe <= w_pop;
      if (w_pop) begin
        r_d    <= r_dest[r_head];
        r_rd   <= r_data[r_head];
        r_head <= r_head + PW'(1);
      end
      r_tail  <= r_tail + PW'(w_enqN);
      r_count <= r_count + CW'(w_enqN) - CW'(w_pop);
    end
  end

  // The mem entry is older, so it takes the tail slot and the ALU entry follows it.
  always_ff @(posedge clock) begin
    if (w_memEnq) begin
      r_dest[r_tail] <= mem_dest;
      r_data[r_tail] <= mem_data;
    end
    if (w_aluEnq) begin
      r_dest[w_aluSlot] <= alu_dest;
      r_data[w_aluSlot] <= alu_data;
    end
  end

  assign d     = r_d;
  assign rd    = r_rd;
  assign rwe   = r_rwe;
  assign count = r_count;

endmodule
